// File: rtl/cim_cmd_sched.sv
// cim_cmd_sched: round-robin command scheduler feeding the CIM array control decoder.
// Expands burst commands into one array access per cycle and adds a drain window after MAC bursts.
module cim_cmd_sched #(
    parameter int unsigned MAC_LAT = 3,
    parameter int unsigned WORD_W  = 8,
    parameter int unsigned LEN_W   = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [1:0]        req0_op,
    input  logic [2:0]        req0_bank,
    input  logic [WORD_W-1:0] req0_word,
    input  logic [LEN_W-1:0]  req0_len,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [1:0]        req1_op,
    input  logic [2:0]        req1_bank,
    input  logic [WORD_W-1:0] req1_word,
    input  logic [LEN_W-1:0]  req1_len,
    output logic [1:0]        arr_op_code,
    output logic [3:0]        arr_bank_sel,
    output logic [WORD_W-1:0] arr_word,
    output logic              arr_issue,
    output logic              busy,
    output logic              done,
    output logic              done_id
);

    localparam logic [1:0] OP_MAC = 2'b00;
    localparam logic [1:0] OP_NOP = 2'b11;
    localparam int unsigned DRAIN_W = (MAC_LAT > 1) ? $clog2(MAC_LAT) : 1;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_e;

    state_e              state_q;
    logic                last_grant_q;
    logic [1:0]          op_q;
    logic [WORD_W-1:0]   cur_word_q;
    logic [LEN_W-1:0]    rem_q;
    logic                id_q;
    logic [DRAIN_W-1:0]  drain_q;

    logic [1:0]          arr_op_q;
    logic [3:0]          arr_bank_q;
    logic [WORD_W-1:0]   arr_word_q;
    logic                arr_issue_q;
    logic                busy_q;
    logic                done_q;
    logic                done_id_q;

    logic                grant_c;
    logic                idle_c;
    logic                hs_c;
    logic [1:0]          sel_op_c;
    logic [2:0]          sel_bank_c;
    logic [WORD_W-1:0]   sel_word_c;
    logic [LEN_W-1:0]    sel_len_c;

    // Round-robin grant: a lone requester wins, a tie goes to the one not served last
    always_comb begin
        grant_c = 1'b0;
        if (req0_valid && req1_valid) begin
            grant_c = ~last_grant_q;
        end else if (req1_valid) begin
            grant_c = 1'b1;
        end
    end

    // Ready is only offered in IDLE and never while reset is being applied
    assign idle_c     = (state_q == IDLE) && !rst_n;
    assign req0_ready = idle_c && req0_valid && !grant_c;
    assign req1_ready = idle_c && req1_valid && grant_c;
    assign hs_c       = req0_ready || req1_ready;

    // Payload of the granted requester
    always_comb begin
        sel_op_c   = grant_c ? req1_op   : req0_op;
        sel_bank_c = grant_c ? req1_bank : req0_bank;
        sel_word_c = grant_c ? req1_word : req0_word;
        sel_len_c  = grant_c ? req1_len  : req0_len;
    end

    // Scheduler FSM; array-side outputs are registered alongside each state transition
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            op_q         <= OP_NOP;
            cur_word_q   <= '0;
            rem_q        <= '0;
            id_q         <= 1'b0;
            drain_q      <= '0;
            arr_op_q     <= OP_NOP;
            arr_bank_q   <= 4'b0000;
            arr_word_q   <= '0;
            arr_issue_q  <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            done_id_q    <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (hs_c) begin
                        op_q         <= sel_op_c;
                        rem_q        <= sel_len_c;
                        id_q         <= grant_c;
                        last_grant_q <= grant_c;
                        busy_q       <= 1'b1;
                        if (sel_op_c == OP_NOP) begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            done_id_q <= grant_c;
                        end else begin
                            state_q     <= ISSUE;
                            arr_issue_q <= 1'b1;
                            arr_op_q    <= sel_op_c;
                            arr_bank_q  <= {1'b1, sel_bank_c};
                            arr_word_q  <= sel_word_c;
                            cur_word_q  <= sel_word_c + WORD_W'(1);
                        end
                    end
                end
                ISSUE: begin
                    if (rem_q == '0) begin
                        arr_issue_q <= 1'b0;
                        arr_op_q    <= OP_NOP;
                        arr_bank_q  <= 4'b0000;
                        arr_word_q  <= '0;
                        if ((op_q == OP_MAC) && (MAC_LAT != 0)) begin
                            state_q <= DRAIN;
                            drain_q <= DRAIN_W'(MAC_LAT - 1);
                        end else begin
                            state_q   <= DONE;
                            done_q    <= 1'b1;
                            done_id_q <= id_q;
                        end
                    end else begin
                        arr_word_q <= cur_word_q;
                        cur_word_q <= cur_word_q + WORD_W'(1);
                        rem_q      <= rem_q - LEN_W'(1);
                    end
                end
                DRAIN: begin
                    if (drain_q == '0) begin
                        state_q   <= DONE;
                        done_q    <= 1'b1;
                        done_id_q <= id_q;
                    end else begin
                        drain_q <= drain_q - DRAIN_W'(1);
                    end
                end
                DONE: begin
                    state_q   <= IDLE;
                    busy_q    <= 1'b0;
                    done_q    <= 1'b0;
                    done_id_q <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign arr_op_code  = arr_op_q;
    assign arr_bank_sel = arr_bank_q;
    assign arr_word     = arr_word_q;
    assign arr_issue    = arr_issue_q;
    assign busy         = busy_q;
    assign done         = done_q;
    assign done_id      = done_id_q;

endmodule

// File: tb/tb_cim_cmd_sched.sv
// Directed testbench for cim_cmd_sched: hand-computed expectations per scenario.
module tb_cim_cmd_sched;

    logic       clk;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic       req0_ready, req1_ready;
    logic [1:0] req0_op, req1_op;
    logic [2:0] req0_bank, req1_bank;
    logic [7:0] req0_word, req1_word;
    logic [3:0] req0_len, req1_len;
    logic [1:0] arr_op_code;
    logic [3:0] arr_bank_sel;
    logic [7:0] arr_word;
    logic       arr_issue, busy, done, done_id;

    int checks = 0;
    int errors = 0;

    cim_cmd_sched #(.MAC_LAT(3), .WORD_W(8), .LEN_W(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op),
        .req0_bank(req0_bank), .req0_word(req0_word), .req0_len(req0_len),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op),
        .req1_bank(req1_bank), .req1_word(req1_word), .req1_len(req1_len),
        .arr_op_code(arr_op_code), .arr_bank_sel(arr_bank_sel), .arr_word(arr_word),
        .arr_issue(arr_issue), .busy(busy), .done(done), .done_id(done_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one clock; inputs are then driven and outputs sampled 1ns after the edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        req0_op = 2'b11; req1_op = 2'b11;
        req0_bank = '0; req1_bank = '0;
        req0_word = '0; req1_word = '0;
        req0_len = '0; req1_len = '0;
        tick(); tick();
        rst_n = 1'b0;
        #1;
        checks++;
        if ({arr_op_code, arr_bank_sel, arr_word, arr_issue, busy, done, done_id, req0_ready, req1_ready}
            !== {2'b11, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL reset_idle got op=%b bank=%b word=%h iss=%b busy=%b done=%b id=%b", arr_op_code,
                     arr_bank_sel, arr_word, arr_issue, busy, done, done_id);
        end
    endtask

    task automatic test_write();
        logic [7:0] ew;
        req0_valid = 1'b1; req0_op = 2'b10; req0_bank = 3'd5; req0_word = 8'h10; req0_len = 4'd2;
        #1;
        checks++;
        if (req0_ready !== 1'b1 || req1_ready !== 1'b0) begin
            errors++;
            $display("FAIL write_ready got r0=%b r1=%b exp r0=1 r1=0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            ew = 8'h10 + 8'(i);
            checks++;
            if ({arr_issue, arr_op_code, arr_bank_sel, arr_word, busy, done} !== {1'b1, 2'b10, 4'b1101, ew, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL write_issue%0d got iss=%b op=%b bank=%b word=%h exp word=%h", i, arr_issue,
                         arr_op_code, arr_bank_sel, arr_word, ew);
            end
            tick();
        end
        checks++;
        if ({done, done_id, busy, arr_issue, arr_op_code} !== {1'b1, 1'b0, 1'b1, 1'b0, 2'b11}) begin
            errors++;
            $display("FAIL write_done got done=%b id=%b busy=%b iss=%b op=%b", done, done_id, busy, arr_issue, arr_op_code);
        end
        tick();
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL write_idle got busy=%b done=%b exp 0 0", busy, done);
        end
    endtask

    task automatic test_mac();
        logic [7:0] ew;
        req1_valid = 1'b1; req1_op = 2'b00; req1_bank = 3'd2; req1_word = 8'hFE; req1_len = 4'd3;
        #1;
        checks++;
        if (req1_ready !== 1'b1 || req0_ready !== 1'b0) begin
            errors++;
            $display("FAIL mac_ready got r0=%b r1=%b exp r0=0 r1=1", req0_ready, req1_ready);
        end
        tick();
        req1_valid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            ew = 8'hFE + 8'(i);
            checks++;
            if ({arr_issue, arr_op_code, arr_bank_sel, arr_word} !== {1'b1, 2'b00, 4'b1010, ew}) begin
                errors++;
                $display("FAIL mac_issue%0d got iss=%b op=%b bank=%b word=%h exp word=%h", i, arr_issue,
                         arr_op_code, arr_bank_sel, arr_word, ew);
            end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({arr_issue, arr_op_code, arr_bank_sel, arr_word, busy, done} !== {1'b0, 2'b11, 4'b0000, 8'h00, 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL mac_drain%0d got iss=%b op=%b bank=%b busy=%b done=%b", i, arr_issue,
                         arr_op_code, arr_bank_sel, busy, done);
            end
            tick();
        end
        checks++;
        if ({done, done_id} !== 2'b11) begin
            errors++;
            $display("FAIL mac_done got done=%b id=%b exp 1 1", done, done_id);
        end
        tick();
    endtask

    task automatic test_alternate();
        logic       g;
        logic [7:0] ew;
        logic [3:0] eb;
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_op = 2'b01; req0_bank = 3'd1; req0_word = 8'h20; req0_len = 4'd0;
        req1_valid = 1'b1; req1_op = 2'b01; req1_bank = 3'd6; req1_word = 8'h40; req1_len = 4'd0;
        #1;
        for (int k = 0; k < 4; k++) begin
            g  = (k % 2) != 0;
            ew = g ? 8'h40 : 8'h20;
            eb = g ? 4'b1110 : 4'b1001;
            checks++;
            if ({req0_ready, req1_ready} !== {~g, g}) begin
                errors++;
                $display("FAIL alt_grant%0d got r0=%b r1=%b exp grant=%0d", k, req0_ready, req1_ready, g);
            end
            tick();
            checks++;
            if ({arr_issue, arr_op_code, arr_bank_sel, arr_word, req0_ready, req1_ready}
                !== {1'b1, 2'b01, eb, ew, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL alt_issue%0d got iss=%b op=%b bank=%b word=%h r0=%b r1=%b", k, arr_issue,
                         arr_op_code, arr_bank_sel, arr_word, req0_ready, req1_ready);
            end
            tick();
            checks++;
            if ({done, done_id, req0_ready, req1_ready} !== {1'b1, g, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL alt_done%0d got done=%b id=%b r0=%b r1=%b exp id=%0d", k, done, done_id,
                         req0_ready, req1_ready, g);
            end
            tick();
        end
        req0_valid = 1'b0; req1_valid = 1'b0;
        #1;
    endtask

    task automatic test_nop();
        req0_valid = 1'b1; req0_op = 2'b11; req0_bank = 3'd3; req0_word = 8'h05; req0_len = 4'd4;
        #1;
        checks++;
        if (req0_ready !== 1'b1) begin
            errors++;
            $display("FAIL nop_ready got %b exp 1", req0_ready);
        end
        tick();
        req0_valid = 1'b0;
        checks++;
        if ({done, done_id, arr_issue, arr_bank_sel, busy} !== {1'b1, 1'b0, 1'b0, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL nop_done got done=%b id=%b iss=%b bank=%b busy=%b", done, done_id, arr_issue,
                     arr_bank_sel, busy);
        end
        tick();
        checks++;
        if ({done, arr_issue, arr_bank_sel, busy} !== {1'b0, 1'b0, 4'b0000, 1'b0}) begin
            errors++;
            $display("FAIL nop_idle got done=%b iss=%b bank=%b busy=%b", done, arr_issue, arr_bank_sel, busy);
        end
    endtask

    task automatic test_reset_mid();
        req0_valid = 1'b1; req0_op = 2'b10; req0_bank = 3'd4; req0_word = 8'h30; req0_len = 4'd7;
        tick();
        req0_valid = 1'b0;
        tick();
        checks++;
        if ({arr_issue, arr_word} !== {1'b1, 8'h31}) begin
            errors++;
            $display("FAIL rmid_issue2 got iss=%b word=%h exp 1 31", arr_issue, arr_word);
        end
        rst_n = 1'b1;
        tick();
        rst_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({arr_op_code, arr_bank_sel, arr_word, arr_issue, busy, done, done_id}
                !== {2'b11, 4'b0000, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL rmid_idle%0d got op=%b bank=%b word=%h iss=%b busy=%b done=%b", i, arr_op_code,
                         arr_bank_sel, arr_word, arr_issue, busy, done);
            end
            if (i < 2) tick();
        end
        req0_valid = 1'b1; req0_op = 2'b01; req0_bank = 3'd0; req0_word = 8'h00; req0_len = 4'd0;
        req1_valid = 1'b1; req1_op = 2'b01; req1_bank = 3'd0; req1_word = 8'h00; req1_len = 4'd0;
        #1;
        checks++;
        if ({req0_ready, req1_ready} !== 2'b10) begin
            errors++;
            $display("FAIL rmid_tie got r0=%b r1=%b exp r0=1 r1=0", req0_ready, req1_ready);
        end
        tick();
        req0_valid = 1'b0; req1_valid = 1'b0;
        tick();
        checks++;
        if ({done, done_id} !== 2'b10) begin
            errors++;
            $display("FAIL rmid_tie_done got done=%b id=%b exp 1 0", done, done_id);
        end
        tick();
    endtask

    task automatic test_busy_wait();
        logic [7:0] ew;
        req0_valid = 1'b1; req0_op = 2'b10; req0_bank = 3'd1; req0_word = 8'h50; req0_len = 4'd2;
        tick();
        req0_valid = 1'b0;
        req0_word  = 8'hAA;
        req0_bank  = 3'd7;
        req1_valid = 1'b1; req1_op = 2'b10; req1_bank = 3'd7; req1_word = 8'h90; req1_len = 4'd0;
        #1;
        for (int i = 0; i < 3; i++) begin
            ew = 8'h50 + 8'(i);
            checks++;
            if ({arr_issue, arr_bank_sel, arr_word, req1_ready} !== {1'b1, 4'b1001, ew, 1'b0}) begin
                errors++;
                $display("FAIL busy_issue%0d got iss=%b bank=%b word=%h r1=%b exp word=%h", i, arr_issue,
                         arr_bank_sel, arr_word, req1_ready, ew);
            end
            tick();
        end
        checks++;
        if ({done, done_id, req1_ready} !== {1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL busy_done got done=%b id=%b r1=%b exp 1 0 0", done, done_id, req1_ready);
        end
        tick();
        checks++;
        if ({req1_ready, req0_ready, busy} !== {1'b1, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL busy_accept got r1=%b r0=%b busy=%b exp 1 0 0", req1_ready, req0_ready, busy);
        end
        tick();
        req1_valid = 1'b0;
        checks++;
        if ({arr_issue, arr_op_code, arr_bank_sel, arr_word} !== {1'b1, 2'b10, 4'b1111, 8'h90}) begin
            errors++;
            $display("FAIL busy_r1_issue got iss=%b op=%b bank=%b word=%h", arr_issue, arr_op_code,
                     arr_bank_sel, arr_word);
        end
        tick();
        checks++;
        if ({done, done_id} !== 2'b11) begin
            errors++;
            $display("FAIL busy_r1_done got done=%b id=%b exp 1 1", done, done_id);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_write();
        test_mac();
        test_alternate();
        test_nop();
        test_reset_mid();
        test_busy_wait();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cim_cmd_sched.md
Name: cim_cmd_sched

Overview:
- Command scheduler in front of the CIM array control decoder.
- Arbitrates two requesters (0 = host load/readback, 1 = compute engine) round-robin.
- Expands each accepted burst command into one array access per cycle on op_code/bank_sel/word.
- After MAC bursts, inserts a drain window so MAC results settle before the next command.

Parameters:
- MAC_LAT, 3, idle cycles inserted after the last MAC issue (0 = no drain).
- WORD_W, 8, word address width.
- LEN_W, 4, burst length field width; burst = len+1 words.

Ports:
- clk  in  1  clock; all logic on rising edge.
- rst_n  in  1  reset, synchronous, active-high (asserted = 1, despite the name).
- req0_valid  in  1  requester 0 command valid.
- req0_ready  out  1  requester 0 command accepted this cycle.
- req0_op  in  2  00 MAC, 01 read, 10 write, 11 NOP.
- req0_bank  in  3  target bank 0..7.
- req0_word  in  WORD_W  start word address.
- req0_len  in  LEN_W  burst length minus one.
- req1_valid, req1_ready, req1_op, req1_bank, req1_word, req1_len: same as requester 0, for requester 1.
- arr_op_code  out  2  to array ctrl op_code; 11 when idle.
- arr_bank_sel  out  4  to array ctrl bank_sel; {1'b1, bank} when issuing, 4'b0000 otherwise.
- arr_word  out  WORD_W  current word address; 0 when not issuing.
- arr_issue  out  1  high on every cycle an access is driven.
- busy  out  1  high in any state other than IDLE.
- done  out  1  one-cycle pulse when a command completes.
- done_id  out  1  requester of the completed command; valid with done, 0 otherwise.

Behaviour:
- Reset (rst_n=1 at clock edge):
  - state goes to IDLE.
  - All outputs take idle values: arr_op_code=11, arr_bank_sel=0, arr_word=0, arr_issue=0, busy=0, done=0, done_id=0, ready=0.
  - last_grant=1, so requester 0 wins the first tie.
  - Reset mid-burst aborts the command with no done pulse.
- FSM states: IDLE, ISSUE, DRAIN, DONE. All arr_* outputs, busy, done and done_id decode from registered state only.
- IDLE:
  - reqX_ready = (state==IDLE) & grant==X & reqX_valid. This is combinational; at most one ready is high.
  - Grant rule: only one valid → that one. Both valid → the requester != last_grant.
  - On handshake: latch op, bank, word, len and id; update last_grant.
  - Next state: ISSUE, or DONE if op==11.
- ISSUE:
  - Drives arr_op_code=op, arr_bank_sel={1,bank}, arr_word=cur_word, arr_issue=1.
  - Each cycle: cur_word increments modulo 2^WORD_W (255 wraps to 0) and remaining decrements.
  - Exactly len+1 issue cycles, back-to-back with no gaps.
  - After the last issue: op==00 and MAC_LAT>0 → DRAIN; otherwise → DONE.
- DRAIN: arr_* outputs at idle values, busy=1. Holds exactly MAC_LAT cycles, then DONE.
- DONE: done=1, done_id=latched id, busy=1, for one cycle; then IDLE.
- Latency:
  - Handshake cycle to first arr_issue: 1 cycle.
  - Total command occupancy: 1 (accept) + (len+1) + drain + 1 (done).
  - Next accept is possible the cycle after DONE.
- Handshake rules:
  - Requesters hold valid and payload stable until ready.
  - Payload is sampled only on the handshake; changes while busy are ignored.
  - No ready while busy; valid seen during busy waits.
- Simultaneous events:
  - A valid rising in the same cycle as DONE is not accepted until the IDLE cycle that follows.
  - Both requesters continuously valid → strict alternation 0,1,0,1...

Test Plan:
- Reset then req0 write, bank 5, word 0x10, len 2 → ready0 pulse; next 3 cycles arr_op_code=10, arr_bank_sel=1101, arr_word 0x10, 0x11, 0x12; then done=1, done_id=0; total 5 cycles busy-to-idle.
- req1 MAC, bank 2, word 0xFE, len 3, MAC_LAT=3 → arr_word FE, FF, 00, 01 with op 00 and bank_sel 1010; then 3 cycles with arr_issue=0 and op 11; then done, done_id=1.
- Both valid continuously from reset, len 0 read commands → grants 0,1,0,1; arr_op_code=01 on issue cycles; each done_id matches the grant order.
- req0 NOP (op 11) → accepted; next cycle done=1; arr_issue never asserts; arr_bank_sel stays 0000.
- Reset asserted during the 2nd issue cycle of a len 7 write → next cycle outputs at idle values, no done pulse; a subsequent tie is granted to req0.
- req1 valid raised while busy with req0 burst → req1_ready stays 0 until the IDLE cycle after done, then pulses; payload changed mid-burst on req0 does not alter arr_word.
